// File: rtl/multicycle_ctlpath.sv
// Multicycle control path for the SiMPLE SV core. It sequences fetch, decode,
// execute, memory and writeback over a shared bus with a ready handshake.
module multicycle_ctlpath #(
  parameter int unsigned M_EXT          = 1,
  parameter int unsigned MUL_DIV_CYCLES = 32,
  parameter int unsigned MEM_TIMEOUT    = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic       inst_bit_30,
  input  logic       inst_bit_25,
  input  logic       alu_result_equal_zero,
  input  logic       mem_ready,
  output logic       inst_mem_read_enable,
  output logic       inst_write_enable,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic       pc_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [1:0] alu_op_mode,
  output logic [2:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       illegal_inst,
  output logic       bus_fault
);

  localparam int unsigned DWELL_W = 8;
  localparam int unsigned WAIT_W  = 16;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MUL_DIV_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit                 TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam bit                 M_ENABLED  = (M_EXT != 0);

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_CMP   = 2'd1;
  localparam logic [1:0] MODE_FUNCT = 2'd2;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_MEM  = 3'd1;
  localparam logic [2:0] WB_PC4  = 3'd2;
  localparam logic [2:0] WB_IMM  = 3'd3;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_IMM = 2'd1;
  localparam logic [1:0] NPC_ALU = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic               illegal_q, illegal_nxt;
  logic               fault_q, fault_nxt;

  logic is_load, is_store, is_op, is_op_imm, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_misc_mem;
  logic is_m_op, legal_c, branch_taken_c, wait_expired_c;
  logic unused_inst_bits;

  // Opcode class decode from the instruction register fields
  assign is_load     = (inst_opcode == OPC_LOAD);
  assign is_store    = (inst_opcode == OPC_STORE);
  assign is_op       = (inst_opcode == OPC_OP);
  assign is_op_imm   = (inst_opcode == OPC_OP_IMM);
  assign is_branch   = (inst_opcode == OPC_BRANCH);
  assign is_jal      = (inst_opcode == OPC_JAL);
  assign is_jalr     = (inst_opcode == OPC_JALR);
  assign is_lui      = (inst_opcode == OPC_LUI);
  assign is_auipc    = (inst_opcode == OPC_AUIPC);
  assign is_misc_mem = (inst_opcode == OPC_MISC_MEM);
  assign is_m_op     = is_op && inst_bit_25;

  assign legal_c = (is_op && (M_ENABLED || !inst_bit_25)) || is_op_imm || is_load ||
                   is_store || is_branch || is_jal || is_jalr || is_lui ||
                   is_auipc || is_misc_mem;

  // funct3 bit 0 inverts the sense (NE/GE/GEU), bit 2 selects the LT-class compare
  assign branch_taken_c = alu_result_equal_zero ^ inst_funct3[0] ^ inst_funct3[2];

  // mem_ready on the limit cycle takes priority over the timeout
  assign wait_expired_c = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT) && !mem_ready;

  // inst[30] feeds the ALU control directly; funct3[1] only matters to the datapath
  assign unused_inst_bits = ^{inst_bit_30, inst_funct3[1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      dwell_cnt <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      wait_cnt  <= wait_nxt;
      illegal_q <= illegal_nxt;
      fault_q   <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    wait_nxt    = wait_cnt;
    illegal_nxt = illegal_q;
    fault_nxt   = fault_q;

    inst_mem_read_enable  = 1'b0;
    inst_write_enable     = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_op_mode           = MODE_ADD;
    reg_writeback_select  = WB_ALU;
    next_pc_select        = NPC_PC4;
    illegal_inst          = illegal_q;
    bus_fault             = fault_q;

    case (state)
      S_FETCH: begin
        inst_mem_read_enable = 1'b1;
        if (mem_ready) begin
          inst_write_enable = 1'b1;
          state_nxt         = S_DECODE;
        end else if (wait_expired_c) begin
          state_nxt = S_TRAP;
          fault_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal_c) begin
          state_nxt = S_EXECUTE;
          dwell_nxt = is_m_op ? DWELL_LOAD : '0;
        end else begin
          state_nxt   = S_TRAP;
          illegal_nxt = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (dwell_cnt != '0) begin
          dwell_nxt = dwell_cnt - DWELL_W'(1);
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
          wait_nxt  = '0;
        end else begin
          state_nxt = S_WRITEBACK;
        end
      end
      S_MEM: begin
        data_mem_read_enable  = is_load;
        data_mem_write_enable = is_store;
        if (mem_ready) begin
          state_nxt = S_WRITEBACK;
        end else if (wait_expired_c) begin
          state_nxt = S_TRAP;
          fault_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        pc_write_enable      = 1'b1;
        regfile_write_enable = is_op || is_op_imm || is_load || is_jal ||
                               is_jalr || is_lui || is_auipc;
        if (is_load)               reg_writeback_select = WB_MEM;
        else if (is_jal || is_jalr) reg_writeback_select = WB_PC4;
        else if (is_lui)           reg_writeback_select = WB_IMM;
        if (is_jal || (is_branch && branch_taken_c)) next_pc_select = NPC_IMM;
        else if (is_jalr)                            next_pc_select = NPC_ALU;
        state_nxt = S_FETCH;
        wait_nxt  = '0;
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    // ALU selects stay stable from execute through writeback (branch compare, JALR target)
    if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
      if (is_load || is_store || is_jalr) begin
        alu_operand_b_select = 1'b1;
      end else if (is_op) begin
        alu_op_mode = MODE_FUNCT;
      end else if (is_op_imm) begin
        alu_operand_b_select = 1'b1;
        alu_op_mode          = MODE_FUNCT;
      end else if (is_branch) begin
        alu_op_mode = MODE_CMP;
      end else if (is_auipc) begin
        alu_operand_a_select = 1'b1;
        alu_operand_b_select = 1'b1;
      end
    end

    if (reset) begin
      inst_mem_read_enable  = 1'b0;
      inst_write_enable     = 1'b0;
      data_mem_read_enable  = 1'b0;
      data_mem_write_enable = 1'b0;
      pc_write_enable       = 1'b0;
      regfile_write_enable  = 1'b0;
      alu_operand_a_select  = 1'b0;
      alu_operand_b_select  = 1'b0;
      alu_op_mode           = MODE_ADD;
      reg_writeback_select  = WB_ALU;
      next_pc_select        = NPC_PC4;
      illegal_inst          = 1'b0;
      bus_fault             = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctlpath.sv
// Scoreboard bench for multicycle_ctlpath: the driver queues the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_multicycle_ctlpath;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Vector: [16]imem_rd [15]ir_we [14]dmem_rd [13]dmem_wr [12]pc_we [11]rf_we
  //         [10]a_sel [9]b_sel [8:7]alu_mode [6:4]wb_sel [3:2]npc_sel [1]illegal [0]fault
  localparam logic [16:0] M_ALL  = 17'h1FFFF;
  localparam logic [16:0] M_WB   = 17'h1F87F;
  localparam logic [16:0] M_EX   = 17'h1FF83;
  localparam logic [16:0] M_EN   = 17'h1F803;
  localparam logic [16:0] F_DONE = 17'h18000;
  localparam logic [16:0] F_WAIT = 17'h10000;
  localparam logic [16:0] V_ILL  = 17'h00002;
  localparam logic [16:0] V_FLT  = 17'h00001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] inst_opcode = '0;
  logic [2:0] inst_funct3 = '0;
  logic       inst_bit_30 = 1'b0;
  logic       inst_bit_25 = 1'b0;
  logic       alu_result_equal_zero = 1'b0;
  logic       mem_ready = 1'b0;

  wire [16:0] vec_a;
  wire [16:0] vec_b;

  always #5 clock = ~clock;

  multicycle_ctlpath #(.M_EXT(1), .MUL_DIV_CYCLES(4), .MEM_TIMEOUT(3)) dut_a (
    .clock(clock), .reset(reset),
    .inst_opcode(inst_opcode), .inst_funct3(inst_funct3),
    .inst_bit_30(inst_bit_30), .inst_bit_25(inst_bit_25),
    .alu_result_equal_zero(alu_result_equal_zero), .mem_ready(mem_ready),
    .inst_mem_read_enable(vec_a[16]), .inst_write_enable(vec_a[15]),
    .data_mem_read_enable(vec_a[14]), .data_mem_write_enable(vec_a[13]),
    .pc_write_enable(vec_a[12]), .regfile_write_enable(vec_a[11]),
    .alu_operand_a_select(vec_a[10]), .alu_operand_b_select(vec_a[9]),
    .alu_op_mode(vec_a[8:7]), .reg_writeback_select(vec_a[6:4]),
    .next_pc_select(vec_a[3:2]), .illegal_inst(vec_a[1]), .bus_fault(vec_a[0])
  );

  multicycle_ctlpath #(.M_EXT(0), .MUL_DIV_CYCLES(32), .MEM_TIMEOUT(0)) dut_b (
    .clock(clock), .reset(reset),
    .inst_opcode(inst_opcode), .inst_funct3(inst_funct3),
    .inst_bit_30(inst_bit_30), .inst_bit_25(inst_bit_25),
    .alu_result_equal_zero(alu_result_equal_zero), .mem_ready(mem_ready),
    .inst_mem_read_enable(vec_b[16]), .inst_write_enable(vec_b[15]),
    .data_mem_read_enable(vec_b[14]), .data_mem_write_enable(vec_b[13]),
    .pc_write_enable(vec_b[12]), .regfile_write_enable(vec_b[11]),
    .alu_operand_a_select(vec_b[10]), .alu_operand_b_select(vec_b[9]),
    .alu_op_mode(vec_b[8:7]), .reg_writeback_select(vec_b[6:4]),
    .next_pc_select(vec_b[3:2]), .illegal_inst(vec_b[1]), .bus_fault(vec_b[0])
  );

  logic [16:0] exp_q[$];
  logic [16:0] mask_q[$];
  bit          sel_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          cur_sel = 1'b0;

  logic [16:0] mon_exp, mon_mask, mon_act;
  bit          mon_sel;
  string       mon_tag;

  function automatic logic [16:0] ex_v(input bit a, input bit b, input logic [1:0] mode);
    return {8'b0, a, b, mode, 3'd0, 2'd0, 2'b00};
  endfunction

  function automatic logic [16:0] wb_v(input bit rfw, input logic [2:0] wbs, input logic [1:0] npc);
    return {4'b0000, 1'b1, rfw, 2'b00, 2'd0, wbs, npc, 2'b00};
  endfunction

  function automatic logic [16:0] mem_v(input bit dr, input bit dw);
    return {2'b00, dr, dw, 2'b00, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'b00};
  endfunction

  task automatic push(input logic [16:0] e, input logic [16:0] m, input string t);
    exp_q.push_back(e);
    mask_q.push_back(m);
    sel_q.push_back(cur_sel);
    tag_q.push_back(t);
  endtask

  task automatic start(input bit sel, input logic [6:0] op, input logic [2:0] f3,
                       input bit b30, input bit b25, input bit eqz, input string t);
    @(posedge clock); #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    cur_sel = sel;
    inst_opcode = op;
    inst_funct3 = f3;
    inst_bit_30 = b30;
    inst_bit_25 = b25;
    alu_result_equal_zero = eqz;
    push('0, M_ALL, {t, ".rst"});
  endtask

  task automatic step(input bit rdy, input bit rst, input logic [16:0] e,
                      input logic [16:0] m, input string t);
    @(posedge clock); #1;
    reset = rst;
    mem_ready = rdy;
    push(e, m, t);
  endtask

  task automatic run_simple(input bit sel, input logic [6:0] op, input logic [2:0] f3,
                            input bit b30, input bit eqz, input logic [16:0] exv,
                            input logic [16:0] exm, input logic [16:0] wbv, input string t);
    start(sel, op, f3, b30, 1'b0, eqz, t);
    step(1'b1, 1'b0, F_DONE, M_EN, {t, ".fetch"});
    step(1'b1, 1'b0, '0,     M_EN, {t, ".decode"});
    step(1'b1, 1'b0, exv,    exm,  {t, ".exec"});
    step(1'b1, 1'b0, wbv,    M_WB, {t, ".wb"});
    step(1'b1, 1'b0, F_DONE, M_EN, {t, ".refetch"});
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_mask = mask_q.pop_front();
      mon_sel  = sel_q.pop_front();
      mon_tag  = tag_q.pop_front();
      mon_act  = mon_sel ? vec_b : vec_a;
      n_tests++;
      if ((mon_act & mon_mask) !== (mon_exp & mon_mask)) begin
        n_fail++;
        $display("FAIL %s: dut_%s got %05h want %05h (mask %05h)", mon_tag,
                 mon_sel ? "b" : "a", mon_act & mon_mask, mon_exp & mon_mask, mon_mask);
      end
    end
  end

  initial begin
    // Non-memory instructions: 4 cycles with mem_ready tied high
    run_simple(1'b0, OPC_OP,     3'b000, 1'b0, 1'b0, ex_v(0, 0, 2'd2), M_EX, wb_v(1, 3'd0, 2'd0), "add");
    run_simple(1'b0, OPC_OP,     3'b000, 1'b1, 1'b0, ex_v(0, 0, 2'd2), M_EX, wb_v(1, 3'd0, 2'd0), "sub");
    run_simple(1'b0, OPC_OPIMM,  3'b000, 1'b0, 1'b0, ex_v(0, 1, 2'd2), M_EX, wb_v(1, 3'd0, 2'd0), "addi");
    run_simple(1'b0, OPC_BRANCH, 3'b001, 1'b0, 1'b0, ex_v(0, 0, 2'd1), M_EX, wb_v(0, 3'd0, 2'd1), "bne_ne");
    run_simple(1'b0, OPC_BRANCH, 3'b001, 1'b0, 1'b1, ex_v(0, 0, 2'd1), M_EX, wb_v(0, 3'd0, 2'd0), "bne_eq");
    run_simple(1'b0, OPC_BRANCH, 3'b101, 1'b0, 1'b1, ex_v(0, 0, 2'd1), M_EX, wb_v(0, 3'd0, 2'd1), "bge_z");
    run_simple(1'b0, OPC_BRANCH, 3'b000, 1'b0, 1'b0, ex_v(0, 0, 2'd1), M_EX, wb_v(0, 3'd0, 2'd0), "beq_ne");
    run_simple(1'b1, OPC_JAL,    3'b000, 1'b0, 1'b0, '0,               M_EN, wb_v(1, 3'd2, 2'd1), "jal");
    run_simple(1'b1, OPC_JALR,   3'b000, 1'b0, 1'b0, ex_v(0, 1, 2'd0), M_EX, wb_v(1, 3'd2, 2'd2), "jalr");
    run_simple(1'b1, OPC_LUI,    3'b000, 1'b0, 1'b0, '0,               M_EN, wb_v(1, 3'd3, 2'd0), "lui");
    run_simple(1'b1, OPC_AUIPC,  3'b000, 1'b0, 1'b0, ex_v(1, 1, 2'd0), M_EX, wb_v(1, 3'd0, 2'd0), "auipc");
    run_simple(1'b1, OPC_MISC,   3'b000, 1'b0, 1'b0, '0,               M_EN, wb_v(0, 3'd0, 2'd0), "fence");

    // LOAD with two wait cycles; ready lands exactly on the timeout limit
    start(1'b0, OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, "lw");
    step(1'b1, 1'b0, F_DONE,           M_EN, "lw.fetch");
    step(1'b1, 1'b0, '0,               M_EN, "lw.decode");
    step(1'b1, 1'b0, ex_v(0, 1, 2'd0), M_EX, "lw.exec");
    step(1'b0, 1'b0, mem_v(1, 0),      M_EX, "lw.mem1");
    step(1'b0, 1'b0, mem_v(1, 0),      M_EX, "lw.mem2");
    step(1'b1, 1'b0, mem_v(1, 0),      M_EX, "lw.mem3");
    step(1'b1, 1'b0, wb_v(1, 3'd1, 2'd0), M_WB, "lw.wb");
    step(1'b1, 1'b0, F_DONE,           M_EN, "lw.refetch");

    // M op dwells 4 execute cycles on the M-enabled instance
    start(1'b0, OPC_OP, 3'b000, 1'b0, 1'b1, 1'b0, "mul");
    step(1'b1, 1'b0, F_DONE, M_EN, "mul.fetch");
    step(1'b1, 1'b0, '0,     M_EN, "mul.decode");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ex_v(0, 0, 2'd2), M_EX, $sformatf("mul.exec%0d", i));
    step(1'b1, 1'b0, wb_v(1, 3'd0, 2'd0), M_WB, "mul.wb");
    step(1'b1, 1'b0, F_DONE, M_EN, "mul.refetch");

    // Same M op is illegal without the extension
    start(1'b1, OPC_OP, 3'b000, 1'b0, 1'b1, 1'b0, "mul_noext");
    step(1'b1, 1'b0, F_DONE, M_EN, "mul_noext.fetch");
    step(1'b1, 1'b0, '0,     M_EN, "mul_noext.decode");
    step(1'b1, 1'b0, V_ILL,  M_EN, "mul_noext.trap1");
    step(1'b1, 1'b0, V_ILL,  M_EN, "mul_noext.trap2");

    start(1'b0, OPC_SYSTEM, 3'b000, 1'b0, 1'b0, 1'b0, "ecall");
    step(1'b1, 1'b0, F_DONE, M_EN, "ecall.fetch");
    step(1'b1, 1'b0, '0,     M_EN, "ecall.decode");
    step(1'b1, 1'b0, V_ILL,  M_EN, "ecall.trap");

    // STORE never acknowledged: fault after 3 MEM cycles, requests drop
    start(1'b0, OPC_STORE, 3'b010, 1'b0, 1'b0, 1'b0, "sw_to");
    step(1'b1, 1'b0, F_DONE,           M_EN, "sw_to.fetch");
    step(1'b1, 1'b0, '0,               M_EN, "sw_to.decode");
    step(1'b1, 1'b0, ex_v(0, 1, 2'd0), M_EX, "sw_to.exec");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, mem_v(0, 1), M_EX, $sformatf("sw_to.mem%0d", i));
    step(1'b0, 1'b0, V_FLT, M_EN, "sw_to.trap1");
    step(1'b1, 1'b0, V_FLT, M_EN, "sw_to.trap2");

    // STORE acknowledged on the third MEM cycle: no fault
    start(1'b0, OPC_STORE, 3'b010, 1'b0, 1'b0, 1'b0, "sw_ok");
    step(1'b1, 1'b0, F_DONE,           M_EN, "sw_ok.fetch");
    step(1'b1, 1'b0, '0,               M_EN, "sw_ok.decode");
    step(1'b1, 1'b0, ex_v(0, 1, 2'd0), M_EX, "sw_ok.exec");
    step(1'b0, 1'b0, mem_v(0, 1),      M_EX, "sw_ok.mem1");
    step(1'b0, 1'b0, mem_v(0, 1),      M_EX, "sw_ok.mem2");
    step(1'b1, 1'b0, mem_v(0, 1),      M_EX, "sw_ok.mem3");
    step(1'b1, 1'b0, wb_v(0, 3'd0, 2'd0), M_WB, "sw_ok.wb");
    step(1'b1, 1'b0, F_DONE,           M_EN, "sw_ok.refetch");

    // Fetch that never completes also faults
    start(1'b0, OPC_OP, 3'b000, 1'b0, 1'b0, 1'b0, "if_to");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, F_WAIT, M_EN, $sformatf("if_to.wait%0d", i));
    step(1'b0, 1'b0, V_FLT, M_EN, "if_to.trap");

    // Reset in the middle of MEM, then a slow fetch
    start(1'b0, OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, "lw_rst");
    step(1'b1, 1'b0, F_DONE,           M_EN,  "lw_rst.fetch");
    step(1'b1, 1'b0, '0,               M_EN,  "lw_rst.decode");
    step(1'b1, 1'b0, ex_v(0, 1, 2'd0), M_EX,  "lw_rst.exec");
    step(1'b0, 1'b0, mem_v(1, 0),      M_EX,  "lw_rst.mem1");
    step(1'b1, 1'b1, '0,               M_ALL, "lw_rst.reset");
    step(1'b0, 1'b0, F_WAIT,           M_EN,  "lw_rst.fetch_w1");
    step(1'b0, 1'b0, F_WAIT,           M_EN,  "lw_rst.fetch_w2");
    step(1'b1, 1'b0, F_DONE,           M_EN,  "lw_rst.fetch_ok");
    step(1'b1, 1'b0, '0,               M_EN,  "lw_rst.decode2");

    @(posedge clock);
    @(negedge clock);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctlpath.md
Name: multicycle_ctlpath

Overview:
Control path FSM for the multicycle RISC-V SiMPLE SV core. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared bus that has a variable-latency ready handshake. It adds a configurable multi-cycle M-extension execute and a bus timeout trap, neither of which the single-cycle control path has. It drives the multicycle datapath and the bus request lines, and takes decoded instruction fields from the instruction decoder.

Parameters:
M_EXT, 1, 1 enables decode of the M-extension (OP opcode with inst_bit_25=1); 0 makes such instructions illegal.
MUL_DIV_CYCLES, 32, EXECUTE dwell in cycles for M ops (range 1..255).
MEM_TIMEOUT, 0, max cycles spent waiting on mem_ready before a bus fault; 0 disables the timeout.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
inst_opcode  in  7  opcode from instruction register
inst_funct3  in  3  funct3
inst_bit_30  in  1  inst[30], passed to ALU control
inst_bit_25  in  1  inst[25], M-op flag
alu_result_equal_zero  in  1  ALU result == 0
mem_ready  in  1  bus completes the current request this cycle
inst_mem_read_enable  out  1  instruction fetch request
inst_write_enable  out  1  latch instruction register
data_mem_read_enable  out  1  load request
data_mem_write_enable  out  1  store request
pc_write_enable  out  1  update PC
regfile_write_enable  out  1  write rd
alu_operand_a_select  out  1  0 = rs1, 1 = PC
alu_operand_b_select  out  1  0 = rs2, 1 = immediate
alu_op_mode  out  2  0 = ADD, 1 = branch compare, 2 = funct-decoded
reg_writeback_select  out  3  0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM
next_pc_select  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU (JALR)
illegal_inst  out  1  sticky trap: illegal opcode
bus_fault  out  1  sticky trap: mem_ready timeout

Behaviour:
- State register: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Outputs are decoded combinationally from the state and the inst_* fields.
- Reset:
  - State goes to FETCH; counters go to 0; traps are cleared.
  - While reset is high, every output is 0 and mem_ready is ignored.
- FETCH:
  - inst_mem_read_enable=1 until mem_ready.
  - On the mem_ready cycle: inst_write_enable=1 and the state goes to DECODE.
- DECODE: one cycle, no enables asserted.
  - Go to EXECUTE.
  - Exception: an illegal opcode goes to TRAP and sets illegal_inst.
  - Legal opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC-MEM (treated as NOP).
  - SYSTEM and all other opcodes are illegal.
  - OP with inst_bit_25=1 and M_EXT=0 is illegal.
- EXECUTE: one cycle, except M ops, which dwell MUL_DIV_CYCLES cycles (8-bit down-counter).
  - LOAD/STORE: a=0, b=1, mode=0; next state MEM.
  - OP: a=0, b=0, mode=2. OP-IMM: a=0, b=1, mode=2.
  - BRANCH: a=0, b=0, mode=1.
  - JALR: a=0, b=1, mode=0. AUIPC: a=1, b=1, mode=0.
  - All opcodes other than LOAD/STORE go to WRITEBACK.
- MEM:
  - data_mem_read_enable (LOAD) or data_mem_write_enable (STORE) is held at 1 until mem_ready.
  - ALU selects are held at their EXECUTE values throughout.
  - On mem_ready, go to WRITEBACK.
- WRITEBACK: one cycle, pc_write_enable=1 always.
  - next_pc_select: 1 for JAL and for a taken BRANCH; 2 for JALR; 0 otherwise.
  - Branch taken = alu_result_equal_zero XOR (funct3[0] XOR funct3[2]).
  - regfile_write_enable=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC.
  - reg_writeback_select: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - Next state FETCH.
- Timeout (MEM_TIMEOUT>0):
  - A wait counter resets on entry to FETCH or MEM and increments each cycle without mem_ready.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP, set bus_fault, drop all requests.
  - mem_ready arriving on the same cycle as the limit wins, so there is no fault.
- TRAP: all enables 0, state and traps stay sticky until reset.
- Minimum latency: 4 cycles per non-memory instruction with mem_ready tied to 1; 5 cycles for a load or store.

Test Plan:
- mem_ready=1, OP ADD (0110011, f3=000, bit30=0) -> FETCH, DECODE, EXECUTE, WB over 4 cycles; WB: regfile_write_enable=1, wb_sel=0, next_pc_select=0, pc_write_enable=1.
- LOAD (0000011), mem_ready low for 2 MEM cycles then high -> data_mem_read_enable=1 for 3 cycles; WB wb_sel=1; 7 cycles total.
- BRANCH BNE (f3=001): alu_result_equal_zero=0 -> next_pc_select=1; =1 -> 0; BGE (f3=101): eq_zero=1 -> 1.
- M_EXT=1, MUL_DIV_CYCLES=4, OP with bit25=1 -> EXECUTE lasts 4 cycles, 7 total; M_EXT=0 -> TRAP after DECODE, illegal_inst=1, all enables 0.
- MEM_TIMEOUT=3, STORE, mem_ready held 0 -> bus_fault=1 after 3 MEM cycles, write_enable drops; mem_ready=1 on the 3rd cycle -> no fault.
- Reset asserted mid-MEM -> all outputs 0 that cycle; after deassert, FETCH with inst_mem_read_enable=1 and traps cleared.
